uart_tx: RTL and testbench

- Serial transmit stage directly downstream of the baud/phase generator.
- Consumes the generator's one-hot frame phase flags: `flag_start`, `flag_data[23:0]` (3 phases per data bit, LSB first) and `flag_end`.
- Accepts bytes over a valid/ready handshake into a one-entry holding register and drives a registered 8N1-style line `tx`.
- Inserts guard frames after each byte so the stop/idle time is always at least one full bit.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial transmit stage that follows the baud/phase generator.
// A byte is accepted over valid/ready into a one-entry holding register,
// moved into a shift register at the next frame start seen in IDLE, and
// sent on a registered 8N1-style line. Each data frame is followed by
// GUARD_FRAMES idle generator frames, so the stop/idle time is at least
// one full bit.
module uart_tx #(
   parameter int GUARD_FRAMES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flag_start,
   input  logic [23:0] flag_data,
   input  logic        flag_end,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        tx,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, GUARD} state_t;

   localparam logic [1:0] GUARD_INIT = 2'(GUARD_FRAMES);

   state_t      state;
   state_t      state_next;
   logic [1:0]  guard_cnt;
   logic [1:0]  guard_cnt_next;
   logic        flag_start_q;
   logic        start_rise;
   logic        hold_full;
   logic        handshake;
   logic        load_shift;
   logic        tx_next;
   logic [7:0]  hold_data;
   logic [7:0]  shift;

   assign start_rise = flag_start & ~flag_start_q;
   assign handshake  = tx_valid & tx_ready;
   assign busy       = (state != IDLE) | hold_full;

   // Next-state, guard count and next line level from the current flags;
   // tx is registered, so it shows these flags one cycle later.
   always_comb begin
      state_next     = state;
      guard_cnt_next = guard_cnt;
      tx_next        = tx;
      load_shift     = 1'b0;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (start_rise && hold_full) begin
               load_shift = 1'b1;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (flag_end) begin
               // A frame that ends before any data phase: treat it as sent.
               state_next     = GUARD;
               guard_cnt_next = GUARD_INIT;
               tx_next        = 1'b1;
            end else if (|flag_data[2:0]) begin
               state_next = DATA;
               tx_next    = shift[0];
            end
         end
         DATA: begin
            if (flag_end) begin
               state_next     = GUARD;
               guard_cnt_next = GUARD_INIT;
               tx_next        = 1'b1;
            end else begin
               // Each data bit owns a group of three phase flags.
               for (int k = 0; k < 8; k++) begin
                  if (|flag_data[3*k +: 3]) tx_next = shift[k];
               end
            end
         end
         GUARD: begin
            tx_next = 1'b1;
            if (flag_end) begin
               if (guard_cnt <= 2'd1) begin
                  guard_cnt_next = 2'd0;
                  state_next     = IDLE;
               end else begin
                  guard_cnt_next = guard_cnt - 2'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   // Control state: FSM, guard count, line register, handshake bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         guard_cnt    <= 2'd0;
         tx           <= 1'b1;
         flag_start_q <= 1'b0;
         hold_full    <= 1'b0;
         tx_ready     <= 1'b1;
      end else begin
         state        <= state_next;
         guard_cnt    <= guard_cnt_next;
         tx           <= tx_next;
         flag_start_q <= flag_start;
         if (handshake) hold_full <= 1'b1;
         else if (load_shift) hold_full <= 1'b0;
         // Drops with the load; comes back one cycle after the register empties.
         tx_ready     <= handshake ? 1'b0 : ~hold_full;
      end
   end

   // Data path: holding register and shift register carry no reset.
   always_ff @(posedge clk) begin
      if (handshake) hold_data <= tx_data;
      if (load_shift) shift <= hold_data;
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives a free-running 28-phase generator frame
// (3 start phases, 24 data phases, 1 end phase) and checks the line,
// tx_ready and busy phase by phase.
module tb_uart_tx;

   logic        clk;
   logic        rst_n;
   logic        flag_start;
   logic [23:0] flag_data;
   logic        flag_end;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready, tx, busy;
   logic        tx_ready3, tx3, busy3;

   int checks = 0;
   int errors = 0;
   int phase = 0;
   int last_phase = 0;

   typedef struct {
      bit         load;
      logic [7:0] ldata;
      bit         active;
      logic [7:0] exp_bits;
      logic       exp_ready;
      logic       exp_busy;
   } row_t;

   row_t rows [10];

   uart_tx #(.GUARD_FRAMES(1)) dut (
      .clk(clk), .rst_n(rst_n), .flag_start(flag_start), .flag_data(flag_data),
      .flag_end(flag_end), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy)
   );

   uart_tx #(.GUARD_FRAMES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flag_start(flag_start), .flag_data(flag_data),
      .flag_end(flag_end), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready3), .tx(tx3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic exp_tx(input int p, input logic [7:0] b);
      if (p < 3) return 1'b0;
      if (p < 27) return b[(p - 3) / 3];
      return 1'b1;
   endfunction

   task automatic drive_phase();
      flag_start = (phase < 3);
      flag_data  = (phase >= 3 && phase < 27) ? (24'd1 << (phase - 3)) : 24'd0;
      flag_end   = (phase == 27);
   endtask

   // One clock: note whether a handshake happens, then advance the generator.
   task automatic step(input bit sel3);
      logic hs;
      hs = tx_valid & (sel3 ? tx_ready3 : tx_ready);
      @(posedge clk);
      #1;
      if (hs) tx_valid = 1'b0;
      last_phase = phase;
      phase = (phase + 1) % 28;
      drive_phase();
   endtask

   task automatic frame(input bit sel3, input bit load, input logic [7:0] ldata,
                        input bit active, input logic [7:0] bits, input string name);
      for (int s = 0; s < 28; s++) begin
         if (load && phase == 13) begin
            tx_valid = 1'b1;
            tx_data  = ldata;
         end
         step(sel3);
         check($sformatf("%s_tx_p%0d", name, last_phase), sel3 ? tx3 : tx,
               active ? exp_tx(last_phase, bits) : 1'b1);
         if (active && last_phase == 0)
            check($sformatf("%s_ready_low", name), sel3 ? tx_ready3 : tx_ready, 1'b0);
         if (active && last_phase == 1)
            check($sformatf("%s_ready_back", name), sel3 ? tx_ready3 : tx_ready, 1'b1);
      end
      tx_valid = 1'b0;
   endtask

   initial begin
      // load, ldata, active, exp_bits, ready at frame end, busy at frame end
      rows[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
      rows[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
      rows[2] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1};
      rows[3] = '{1'b0, 8'h00, 1'b1, 8'b1010_0101, 1'b1, 1'b1};
      rows[4] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
      rows[5] = '{1'b1, 8'hFF, 1'b1, 8'b0000_0000, 1'b0, 1'b1};
      rows[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
      rows[7] = '{1'b0, 8'h00, 1'b1, 8'b1111_1111, 1'b1, 1'b1};
      rows[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
      rows[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

      rst_n = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      flag_start = 1'b0;
      flag_data = 24'd0;
      flag_end = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", tx, 1'b1);
      check("reset_ready", tx_ready, 1'b1);
      check("reset_busy", busy, 1'b0);

      rst_n = 1'b1;
      phase = 0;
      drive_phase();

      for (int i = 0; i < 10; i++) begin
         frame(1'b0, rows[i].load, rows[i].ldata, rows[i].active, rows[i].exp_bits,
               $sformatf("row%0d", i));
         check($sformatf("row%0d_ready_end", i), tx_ready, rows[i].exp_ready);
         check($sformatf("row%0d_busy_end", i), busy, rows[i].exp_busy);
      end

      // Reset in the middle of data bit 3 of 0x3C.
      frame(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, "ld3c");
      for (int s = 0; s < 13; s++) begin
         step(1'b0);
         check($sformatf("b3c_tx_p%0d", last_phase), tx, exp_tx(last_phase, 8'h3C));
      end
      check("b3c_busy_before_rst", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_ready", tx_ready, 1'b1);
      while (phase != 20) begin
         step(1'b0);
         check("in_rst_tx", tx, 1'b1);
      end
      rst_n = 1'b1;
      while (phase != 0) begin
         step(1'b0);
         check($sformatf("post_rst_tx_p%0d", last_phase), tx, 1'b1);
      end
      frame(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "post_rst_idle");
      check("post_rst_busy", busy, 1'b0);
      frame(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, "ld5a");
      frame(1'b0, 1'b0, 8'h00, 1'b1, 8'b0101_1010, "tx5a");
      frame(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "guard5a");

      // Three guard frames: the second byte starts four frames after the first.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      frame(1'b1, 1'b1, 8'h81, 1'b0, 8'h00, "g3_ld81");
      frame(1'b1, 1'b1, 8'h42, 1'b1, 8'b1000_0001, "g3_tx81");
      check("g3_busy_guard", busy3, 1'b1);
      frame(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "g3_guard1");
      frame(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "g3_guard2");
      frame(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "g3_guard3");
      frame(1'b1, 1'b0, 8'h00, 1'b1, 8'b0100_0010, "g3_tx42");
      frame(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, "g3_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
